// File: rtl/wb_pkg.sv
// Shared widths, the zero-register constant and the queued-result record
// for the writeback arbiter.
package wb_pkg;

  localparam int REG_W  = 5;
  localparam int DATA_W = 32;

  localparam logic [REG_W-1:0] ZERO_REG = '0;

  // "reg" is a keyword, so the destination field is called wreg
  typedef struct packed {
    logic              live;
    logic [REG_W-1:0]  wreg;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Circular buffer for secondary results with per-entry kill-by-register
// and a combinational "any live entry targets queryReg" output.
module wb_fifo
  import wb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  wb_entry_t        pushEntry,
  input  logic             pop,
  input  logic             killEn,
  input  logic [REG_W-1:0] killReg,
  input  logic [REG_W-1:0] queryReg,
  output logic             full,
  output logic             empty,
  output wb_entry_t        head,
  output logic             matchAny
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int PW = AW + 1;

  logic [PW-1:0]     wrPtr;
  logic [PW-1:0]     rdPtr;
  logic [AW-1:0]     wrIdx;
  logic [AW-1:0]     rdIdx;
  logic [REG_W-1:0]  regMem  [DEPTH];
  logic [DATA_W-1:0] dataMem [DEPTH];
  logic [DEPTH-1:0]  liveBits;
  logic [DEPTH-1:0]  matchVec;
  logic              doPush;
  logic              doPop;

  assign wrIdx  = wrPtr[AW-1:0];
  assign rdIdx  = rdPtr[AW-1:0];
  assign empty  = (wrPtr == rdPtr);
  assign full   = (wrPtr[AW] != rdPtr[AW]) && (wrIdx == rdIdx);
  assign doPush = push && !full;
  assign doPop  = pop && !empty;

  always_ff @(posedge clock) begin
    if (reset) begin
      wrPtr <= '0;
      rdPtr <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + PW'(1);
      if (doPop)  rdPtr <= rdPtr + PW'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (doPush) begin
      regMem[wrIdx]  <= pushEntry.wreg;
      dataMem[wrIdx] <= pushEntry.data;
    end
  end

  // Live bits double as occupancy: a slot is cleared on pop, so only
  // queued, unkilled entries can ever match a kill or a query.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
      always_ff @(posedge clock) begin
        if (reset) begin
          liveBits[gi] <= 1'b0;
        end else if (doPush && (wrIdx == AW'(gi))) begin
          liveBits[gi] <= pushEntry.live;
        end else if ((doPop && (rdIdx == AW'(gi))) ||
                     (killEn && (regMem[gi] == killReg))) begin
          liveBits[gi] <= 1'b0;
        end
      end

      assign matchVec[gi] = liveBits[gi] && (regMem[gi] == queryReg);
    end
  endgenerate

  always_comb begin
    head.live = liveBits[rdIdx];
    head.wreg = regMem[rdIdx];
    head.data = dataMem[rdIdx];
  end

  assign matchAny = |matchVec;

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: merges the primary path and the queued secondary unit
// into one registered regfile write. Optional forwarding port: WB_BYPASS_EN.
module wb_arbiter
  import wb_pkg::*;
#(
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              pri_valid,
  input  logic [REG_W-1:0]  pri_reg,
  input  logic [DATA_W-1:0] pri_data,
  output logic              pri_stall,
  input  logic              sec_valid,
  output logic              sec_ready,
  input  logic [REG_W-1:0]  sec_reg,
  input  logic [DATA_W-1:0] sec_data,
  input  logic [REG_W-1:0]  query_reg,
  output logic              query_pending,
  output logic              ctrl_writeEn,
  output logic [REG_W-1:0]  ctrl_writeReg,
  output logic [DATA_W-1:0] data_writeReg
`ifdef WB_BYPASS_EN
  ,
  output logic              fwd_valid,
  output logic [REG_W-1:0]  fwd_reg,
  output logic [DATA_W-1:0] fwd_data
`endif
);

  localparam int CW = $clog2(STARVE_LIMIT + 1);

  logic          fifoFull;
  logic          fifoEmpty;
  logic          fifoMatch;
  logic          secPush;
  logic          priTake;
  logic          priUses;
  logic          popHead;
  logic          headLive;
  logic          starveInc;
  wb_entry_t     head;
  wb_entry_t     pushEntry;
  logic [CW-1:0] starveCnt;

  assign sec_ready = !fifoFull && !reset;
  assign secPush   = sec_valid && sec_ready;

  // A primary write to $0 leaves the slot free for the FIFO head.
  assign priTake   = pri_valid && !pri_stall;
  assign priUses   = priTake && (pri_reg != ZERO_REG);
  assign popHead   = !fifoEmpty && !priUses;
  assign headLive  = !fifoEmpty && head.live;
  assign starveInc = headLive && !popHead;

  always_comb begin
    pushEntry.live = (sec_reg != ZERO_REG);
    pushEntry.wreg = sec_reg;
    pushEntry.data = sec_data;
  end

  wb_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (secPush),
    .pushEntry (pushEntry),
    .pop       (popHead),
    .killEn    (priUses),
    .killReg   (pri_reg),
    .queryReg  (query_reg),
    .full      (fifoFull),
    .empty     (fifoEmpty),
    .head      (head),
    .matchAny  (fifoMatch)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      ctrl_writeEn  <= 1'b0;
      ctrl_writeReg <= '0;
      data_writeReg <= '0;
      pri_stall     <= 1'b0;
      starveCnt     <= '0;
    end else begin
      ctrl_writeEn <= 1'b0;
      if (priUses) begin
        ctrl_writeEn  <= 1'b1;
        ctrl_writeReg <= pri_reg;
        data_writeReg <= pri_data;
      end else if (popHead && head.live) begin
        ctrl_writeEn  <= 1'b1;
        ctrl_writeReg <= head.wreg;
        data_writeReg <= head.data;
      end
      // Stall lands in the cycle the counter reads STARVE_LIMIT-1; the
      // forced pop in that cycle clears both counter and stall.
      starveCnt <= starveInc ? starveCnt + CW'(1) : '0;
      pri_stall <= starveInc && ((starveCnt + CW'(1)) == CW'(STARVE_LIMIT - 1));
    end
  end

  assign query_pending = (query_reg != ZERO_REG) &&
                         (fifoMatch || (ctrl_writeEn && (ctrl_writeReg == query_reg)));

`ifdef WB_BYPASS_EN
  assign fwd_valid = ctrl_writeEn && !reset;
  assign fwd_reg   = ctrl_writeReg;
  assign fwd_data  = data_writeReg;
`endif

endmodule
